id_stage_ctrl: RTL and testbench

//  Controller for the decode stage of the 5-stage RV32I pipeline. Owns the IF/ID pipeline register (pc, instruction, valid).

---
 rtl/id_stage_ctrl_pkg.sv | 29 ++
 rtl/id_stage_ctrl_src_use.sv | 40 ++++
 rtl/id_stage_ctrl.sv | 140 ++++++++++++++
 tb/tb_id_stage_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : id_stage_ctrl_pkg                                      |
// | Brief   : RV32I opcodes, NOP encoding and decode-stage FSM states |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package id_stage_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DROP  = 2'd2
    } id_state_e;

endpackage : id_stage_ctrl_pkg
`default_nettype wire

// File: rtl/id_stage_ctrl_src_use.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : id_src_use                                             |
// | Brief   : Extracts rs1/rs2 fields and whether each is really read |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module id_src_use
    import id_stage_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        use_rs1_o,
    output logic        use_rs2_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o
);

    logic [6:0] w_opcode;
    logic       w_unused_bits;

    assign w_opcode      = instr_i[6:0];
    assign rs1_o         = instr_i[19:15];
    assign rs2_o         = instr_i[24:20];
    assign w_unused_bits = ^{instr_i[31:25], instr_i[14:7]};

    // Only U-type and JAL lack rs1; only R/S/B formats carry a real rs2
    always_comb begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b0;
        case (w_opcode)
            LUI, AUIPC, JAL: use_rs1_o = 1'b0;
            default:         use_rs1_o = 1'b1;
        endcase
        case (w_opcode)
            R_TYPE, S_TYPE, B_TYPE: use_rs2_o = 1'b1;
            default:                use_rs2_o = 1'b0;
        endcase
    end

endmodule : id_src_use
`default_nettype wire

// File: rtl/id_stage_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : id_stage_ctrl                                          |
// | Brief   : IF/ID register, load-use stall, redirect squash and    |
// |           saturating stall/flush performance counters            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int PERF_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [31:0]       if_pc_i,
    input  logic [31:0]       if_instr_i,
    output logic              if_ready_o,
    input  logic              ex_ready_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_redirect_i,
    output logic              id_valid_o,
    output logic [31:0]       id_pc_o,
    output logic [31:0]       id_instr_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    localparam logic [1:0] DROP_LOAD = 2'(REDIRECT_BUBBLES);

    id_state_e         state_q;
    logic              id_valid_q;
    logic [31:0]       id_pc_q;
    logic [31:0]       id_instr_q;
    logic [1:0]        drop_cnt_q;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    logic              w_use_rs1, w_use_rs2;
    logic [4:0]        w_rs1, w_rs2;
    logic              w_hazard;
    logic              w_fire;
    logic              w_if_beat;

    id_src_use u_src_use (
        .instr_i   (id_instr_q),
        .use_rs1_o (w_use_rs1),
        .use_rs2_o (w_use_rs2),
        .rs1_o     (w_rs1),
        .rs2_o     (w_rs2)
    );

    // Load-use hazard: the ID instruction reads the register a load in EX is still fetching
    assign w_hazard = id_valid_q & ex_is_load_i & (ex_rd_i != 5'd0) &
                      ((w_use_rs1 & (w_rs1 == ex_rd_i)) | (w_use_rs2 & (w_rs2 == ex_rd_i)));
    assign w_fire     = id_valid_q & ex_ready_i & ~w_hazard;
    assign if_ready_o = ~rst & (state_q != ST_DROP) & (~id_valid_q | w_fire);
    assign w_if_beat  = if_valid_i & if_ready_o;

    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Control FSM, drop counter and IF/ID pipeline register (redirect squashes everything)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_instr_q <= NOP_INSTR;
            drop_cnt_q <= 2'd0;
        end else begin
            if (ex_redirect_i) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end else if (w_if_beat) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= if_pc_i;
                id_instr_q <= if_instr_i;
            end else if (w_fire) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end

            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (ex_redirect_i) begin
                        state_q    <= ST_DROP;
                        drop_cnt_q <= DROP_LOAD;
                    end else if (w_hazard) begin
                        state_q <= ST_STALL;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (ex_redirect_i) begin
                        drop_cnt_q <= DROP_LOAD;
                    end else if (drop_cnt_q <= 2'd1) begin
                        state_q    <= ST_RUN;
                        drop_cnt_q <= 2'd0;
                    end else begin
                        drop_cnt_q <= drop_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    drop_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    // Saturating increments; a flush in the same cycle as a hazard is not a stall
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_hazard && !ex_redirect_i && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if (ex_redirect_i && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule : id_stage_ctrl
`default_nettype wire

// File: tb/tb_id_stage_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_id_stage_ctrl                                       |
// | Brief   : Directed + randomized bench against a cycle model      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_id_stage_ctrl;
    import id_stage_ctrl_pkg::*;

    localparam int RB = 2;
    localparam int PW = 4;
    localparam int SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [31:0]   if_pc, if_instr;
    logic          if_ready;
    logic          ex_ready, ex_is_load, ex_redirect;
    logic [4:0]    ex_rd;
    logic          id_valid;
    logic [31:0]   id_pc, id_instr;
    logic [PW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_v;
    logic [31:0] m_pc, m_instr;
    int          m_drop, m_stall, m_flush;
    bit          exp_ready, act_ready;

    id_stage_ctrl #(.REDIRECT_BUBBLES(RB), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid), .if_pc_i(if_pc), .if_instr_i(if_instr), .if_ready_o(if_ready),
        .ex_ready_i(ex_ready), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_redirect_i(ex_redirect),
        .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, I_TYPE};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, R_TYPE};
    endfunction
    // Non-R formats with register-looking fields in bits [24:15] so only the use rules prevent stalls
    function automatic logic [31:0] enc_fmt(input logic [6:0] op, input logic [4:0] f1, input logic [4:0] f2);
        return {7'd0, f2, f1, 3'b000, 5'd1, op};
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Hazard from the architectural rule: does ID read a register an EX load will write?
    function automatic bit m_hazard();
        logic [6:0] op;
        bit u1, u2;
        op = m_instr[6:0];
        u1 = !(op == LUI || op == AUIPC || op == JAL);
        u2 = (op == R_TYPE || op == S_TYPE || op == B_TYPE);
        return m_v && ex_is_load && (ex_rd != 5'd0) &&
               ((u1 && m_instr[19:15] == ex_rd) || (u2 && m_instr[24:20] == ex_rd));
    endfunction

    // Advance one clock: predict if_ready, sample it, then update the model at the edge
    task automatic cycle();
        bit haz, fire;
        haz  = m_hazard();
        fire = m_v && ex_ready && !haz;
        exp_ready = !rst && (m_drop == 0) && (!m_v || fire);
        @(negedge clk);
        act_ready = if_ready;
        @(posedge clk);
        if (rst) begin
            m_v = 0; m_pc = 0; m_instr = NOP_INSTR; m_drop = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (haz && !ex_redirect) m_stall++;
            if (ex_redirect) begin
                m_flush++;
                m_v = 0;
                m_drop = RB;
            end else begin
                if (m_drop > 0) m_drop--;
                if (if_valid && exp_ready) begin
                    m_v = 1; m_pc = if_pc; m_instr = if_instr;
                end else if (fire) begin
                    m_v = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; if_valid = 0; if_pc = 0; if_instr = 0;
        ex_ready = 1; ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got=%0b exp=0", act_ready); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        n_checks++; if (id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_id_instr got=%h exp=00000013", id_instr); end
        n_checks++; if (id_pc !== 32'd0) begin n_fail++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        n_checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        rst = 0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            if_valid = 1; if_pc = 32'h100 + 32'(4 * k); if_instr = enc_addi(5'(k + 1), 5'd0, 12'(k));
            cycle();
            n_checks++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", k, act_ready); end
            n_checks++; if (id_valid !== 1'b1 || id_pc !== if_pc || id_instr !== if_instr) begin
                n_fail++; $display("FAIL b2b_id[%0d] got=%0b/%h/%h exp=1/%h/%h", k, id_valid, id_pc, id_instr, if_pc, if_instr); end
            n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL b2b_stall[%0d] got=%0d exp=0", k, stall_cnt); end
        end
        if_valid = 0;
        cycle();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%0b exp=0", id_valid); end
    endtask

    task automatic test_load_use();
        logic [31:0] add_i, nxt_i;
        add_i = enc_add(5'd6, 5'd5, 5'd7);
        nxt_i = enc_addi(5'd8, 5'd0, 12'd1);
        if_valid = 1; if_pc = 32'h200; if_instr = add_i;
        cycle();
        if_pc = 32'h204; if_instr = nxt_i; ex_is_load = 1; ex_rd = 5'd5;
        cycle();
        n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready got=%0b exp=0", act_ready); end
        n_checks++; if (id_valid !== 1'b1 || id_instr !== add_i) begin n_fail++; $display("FAIL lu_hold got=%0b/%h exp=1/%h", id_valid, id_instr, add_i); end
        n_checks++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL lu_stall got=%0d exp=1", stall_cnt); end
        ex_is_load = 0;
        cycle();
        n_checks++; if (act_ready !== 1'b1 || id_instr !== nxt_i) begin n_fail++; $display("FAIL lu_release got=%0b/%h exp=1/%h", act_ready, id_instr, nxt_i); end
        if_valid = 0;
        cycle();
    endtask

    task automatic test_no_hazard();
        logic [31:0] ins [3];
        logic [4:0]  rds [3];
        ins[0] = enc_add(5'd6, 5'd0, 5'd0); rds[0] = 5'd0;
        ins[1] = enc_fmt(LUI, 5'd5, 5'd5);  rds[1] = 5'd5;
        ins[2] = enc_fmt(JAL, 5'd5, 5'd5);  rds[2] = 5'd5;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1; if_pc = 32'h300 + 32'(4 * k); if_instr = ins[k]; ex_is_load = 0;
            cycle();
            if_valid = 0; ex_is_load = 1; ex_rd = rds[k];
            cycle();
            n_checks++; if (act_ready !== 1'b1 || id_valid !== 1'b0) begin n_fail++; $display("FAIL nohaz[%0d] got=%0b/%0b exp=1/0", k, act_ready, id_valid); end
            n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL nohaz_stall[%0d] got=%0d exp=1", k, stall_cnt); end
        end
        ex_is_load = 0;
    endtask

    task automatic test_redirect();
        if_valid = 1; if_pc = 32'h400; if_instr = enc_addi(5'd1, 5'd1, 12'd1);
        cycle();
        ex_redirect = 1; if_pc = 32'h404;
        cycle();
        ex_redirect = 0; if_pc = 32'h800;
        n_checks++; if (id_valid !== 1'b0 || flush_cnt !== 4'd1) begin n_fail++; $display("FAIL redir_flush got=%0b/%0d exp=0/1", id_valid, flush_cnt); end
        for (int k = 0; k < RB; k++) begin
            cycle();
            n_checks++; if (act_ready !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop[%0d] got=%0b/%0b exp=0/0", k, act_ready, id_valid); end
        end
        cycle();
        n_checks++; if (act_ready !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h800) begin
            n_fail++; $display("FAIL redir_resume got=%0b/%0b/%h exp=1/1/00000800", act_ready, id_valid, id_pc); end
        if_valid = 0;
        cycle();
    endtask

    task automatic test_redirect_hazard();
        if_valid = 1; if_pc = 32'h500; if_instr = enc_add(5'd6, 5'd5, 5'd7);
        cycle();
        if_valid = 0; ex_is_load = 1; ex_rd = 5'd5; ex_redirect = 1;
        cycle();
        ex_is_load = 0; ex_redirect = 0;
        n_checks++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd2) begin n_fail++; $display("FAIL rh_counts got=%0d/%0d exp=1/2", stall_cnt, flush_cnt); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_squash got=%0b exp=0", id_valid); end
        if_valid = 1; if_pc = 32'h900;
        cycle();
        n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL rh_drop got=%0b exp=0", act_ready); end
        if_valid = 0;
        for (int k = 0; k < RB; k++) cycle();
    endtask

    task automatic test_reset_mid_stall();
        if_valid = 1; if_pc = 32'h600; if_instr = enc_add(5'd6, 5'd5, 5'd7);
        cycle();
        if_valid = 0; ex_is_load = 1; ex_rd = 5'd7; ex_ready = 0;
        cycle();
        rst = 1;
        cycle();
        n_checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_stall_id got=%0b/%h exp=0/00000013", id_valid, id_instr); end
        n_checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL rst_stall_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        idle_inputs();
        if_valid = 1; if_pc = 32'h700; if_instr = enc_addi(5'd2, 5'd0, 12'd7);
        cycle();
        n_checks++; if (act_ready !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h700) begin
            n_fail++; $display("FAIL rst_stall_run got=%0b/%0b/%h exp=1/1/00000700", act_ready, id_valid, id_pc); end
        if_valid = 0;
        cycle();
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        ops[0] = R_TYPE; ops[1] = I_TYPE; ops[2] = LOAD; ops[3] = S_TYPE;
        ops[4] = B_TYPE; ops[5] = JAL;    ops[6] = LUI;  ops[7] = AUIPC;
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            if_valid    = $urandom_range(0, 3) != 0;
            if_pc       = $urandom & 32'hFFFF_FFFC;
            if_instr    = enc_fmt(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            ex_ready    = $urandom_range(0, 3) != 0;
            ex_is_load  = $urandom_range(0, 1) != 0;
            ex_rd       = 5'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 11) == 0);
            cycle();
            n_checks++; if (act_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, act_ready, exp_ready); end
            n_checks++; if (id_valid !== m_v || id_pc !== m_pc || id_instr !== (m_v ? m_instr : NOP_INSTR)) begin
                n_fail++; $display("FAIL rnd_id[%0d] got=%0b/%h/%h exp=%0b/%h/%h", n, id_valid, id_pc, id_instr, m_v, m_pc, m_v ? m_instr : NOP_INSTR); end
            n_checks++; if (int'(stall_cnt) != sat(m_stall) || int'(flush_cnt) != sat(m_flush)) begin
                n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, sat(m_stall), sat(m_flush)); end
        end
        idle_inputs();
    endtask

    initial begin
        m_v = 0; m_pc = 0; m_instr = NOP_INSTR; m_drop = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_redirect_hazard();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_stage_ctrl
`default_nettype wire
